// File: rtl/bka_seq_add32_if.sv
// Operand/result handshake bundle for the sequential 32-bit adder.
// The slave side is the adder; the master side feeds operands and drains results.
interface bka_seq_add32_if;
    logic        in_valid;
    logic        in_ready;
    logic [32:1] a;
    logic [32:1] b;
    logic        cin;
    logic        out_valid;
    logic        out_ready;
    logic [32:1] sum;
    logic        cout;
    logic        ovf;

    modport slave (
        input  in_valid, a, b, cin, out_ready,
        output in_ready, out_valid, sum, cout, ovf
    );

    modport master (
        output in_valid, a, b, cin, out_ready,
        input  in_ready, out_valid, sum, cout, ovf
    );
endinterface

// File: rtl/bka_seq_add32.sv
// 32-bit add (sum, cout, signed ovf) through one 16-bit Brent-Kung adder, one half per cycle.
// Latency: result valid two edges after accept; in_ready only in IDLE; result held until out_ready.
module bk_add16 (
    output logic [15:0] S,
    output logic        Cout,
    input  logic [15:0] A,
    input  logic [15:0] B,
    input  logic        Cin
);
    // Each mask selects the bit positions combined at one level of the prefix tree.
    localparam logic [15:0] M_U1 = 16'hAAAA;
    localparam logic [15:0] M_U2 = 16'h8888;
    localparam logic [15:0] M_U4 = 16'h8080;
    localparam logic [15:0] M_U8 = 16'h8000;
    localparam logic [15:0] M_D4 = 16'h0800;
    localparam logic [15:0] M_D2 = 16'h2220;
    localparam logic [15:0] M_D1 = 16'h5554;

    logic [15:0] p0, g0;
    logic [15:0] g1, p1, g2, p2, g3, p3, g4, p4, g5, p5, g6, p6, g7;

    assign p0 = A ^ B;
    assign g0 = (A & B) | {15'd0, p0[0] & Cin};

    assign g1 = g0 | (p0 & (g0 << 1) & M_U1);
    assign p1 = p0 & ((p0 << 1) | ~M_U1);
    assign g2 = g1 | (p1 & (g1 << 2) & M_U2);
    assign p2 = p1 & ((p1 << 2) | ~M_U2);
    assign g3 = g2 | (p2 & (g2 << 4) & M_U4);
    assign p3 = p2 & ((p2 << 4) | ~M_U4);
    assign g4 = g3 | (p3 & (g3 << 8) & M_U8);
    assign p4 = p3 & ((p3 << 8) | ~M_U8);

    assign g5 = g4 | (p4 & (g4 << 4) & M_D4);
    assign p5 = p4 & ((p4 << 4) | ~M_D4);
    assign g6 = g5 | (p5 & (g5 << 2) & M_D2);
    assign p6 = p5 & ((p5 << 2) | ~M_D2);
    assign g7 = g6 | (p6 & (g6 << 1) & M_D1);

    assign S    = p0 ^ {g7[14:0], Cin};
    assign Cout = g7[15];
endmodule

module bka_seq_add32 (
    input  logic            clk,
    input  logic            rst,
    bka_seq_add32_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, LO, HI, HOLD} state_t;

    state_t      state_q, state_d;
    logic [32:1] a_q, a_d, b_q, b_d, sum_q, sum_d;
    logic        cin_q, cin_d;
    logic [16:1] sum_lo_q, sum_lo_d;
    logic        carry_lo_q, carry_lo_d;
    logic        cout_q, cout_d, ovf_q, ovf_d, out_valid_q, out_valid_d;

    logic [16:1] add_a, add_b, add_s;
    logic        add_ci, add_co;

    // The upper half sees the lower half only through carry_lo_q.
    assign add_a  = (state_q == HI) ? a_q[32:17] : a_q[16:1];
    assign add_b  = (state_q == HI) ? b_q[32:17] : b_q[16:1];
    assign add_ci = (state_q == HI) ? carry_lo_q : cin_q;

    bk_add16 u_bk (
        .S    (add_s),
        .Cout (add_co),
        .A    (add_a),
        .B    (add_b),
        .Cin  (add_ci)
    );

    always_comb begin
        state_d     = state_q;
        a_d         = a_q;
        b_d         = b_q;
        cin_d       = cin_q;
        sum_lo_d    = sum_lo_q;
        carry_lo_d  = carry_lo_q;
        sum_d       = sum_q;
        cout_d      = cout_q;
        ovf_d       = ovf_q;
        out_valid_d = out_valid_q;
        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    a_d     = bus.a;
                    b_d     = bus.b;
                    cin_d   = bus.cin;
                    state_d = LO;
                end
            end
            LO: begin
                sum_lo_d   = add_s;
                carry_lo_d = add_co;
                state_d    = HI;
            end
            HI: begin
                sum_d       = {add_s, sum_lo_q};
                cout_d      = add_co;
                ovf_d       = (a_q[32] == b_q[32]) && (add_s[16] != a_q[32]);
                out_valid_d = 1'b1;
                state_d     = HOLD;
            end
            HOLD: begin
                if (bus.out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            a_q         <= '0;
            b_q         <= '0;
            cin_q       <= 1'b0;
            sum_lo_q    <= '0;
            carry_lo_q  <= 1'b0;
            sum_q       <= '0;
            cout_q      <= 1'b0;
            ovf_q       <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            b_q         <= b_d;
            cin_q       <= cin_d;
            sum_lo_q    <= sum_lo_d;
            carry_lo_q  <= carry_lo_d;
            sum_q       <= sum_d;
            cout_q      <= cout_d;
            ovf_q       <= ovf_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign bus.in_ready  = (state_q == IDLE) && !rst;
    assign bus.out_valid = out_valid_q;
    assign bus.sum       = sum_q;
    assign bus.cout      = cout_q;
    assign bus.ovf       = ovf_q;
endmodule

// File: tb/tb_bka_seq_add32.sv
// Bench for bka_seq_add32: directed corner cases plus randomized operations against a 33-bit arithmetic model.
module tb_bka_seq_add32;
    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_fail   = 0;

    bka_seq_add32_if bus ();

    bka_seq_add32 dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
        $fatal(1, "watchdog");
    end

    // Reference: {ovf, cout, sum} from plain 33-bit arithmetic.
    function automatic logic [34:1] ref_add(input logic [32:1] a, input logic [32:1] b, input logic c);
        logic [32:0] t;
        logic        ov;
        t  = {1'b0, a} + {1'b0, b} + {32'd0, c};
        ov = (a[32] == b[32]) && (t[31] != a[32]);
        return {ov, t[32], t[31:0]};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic accept(input logic [32:1] a, input logic [32:1] b, input logic c, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (bus.in_ready === 1'b1) begin
                ok = 1'b1;
                break;
            end
            step();
        end
        bus.a        = a;
        bus.b        = b;
        bus.cin      = c;
        bus.in_valid = ok;
        step();
        bus.in_valid = 1'b0;
    endtask

    task automatic run_op(input logic [32:1] a, input logic [32:1] b, input logic c, output bit ok,
                          output logic v1, output logic v2, output logic [34:1] res);
        accept(a, b, c, ok);
        step();
        v1 = bus.out_valid;
        step();
        v2  = bus.out_valid;
        res = {bus.ovf, bus.cout, bus.sum};
    endtask

    task automatic release_op();
        bus.out_ready = 1'b1;
        step();
        bus.out_ready = 1'b0;
    endtask

    task automatic test_reset();
        logic [34:1] got;
        rst = 1'b1;
        bus.in_valid = 1'b0; bus.out_ready = 1'b0;
        bus.a = '0; bus.b = '0; bus.cin = 1'b0;
        #2;
        got = {bus.ovf, bus.cout, bus.sum};
        n_checks++;
        if (got !== 34'd0) begin n_fail++; $display("FAIL reset_outputs: got %h required 0", got); end
        n_checks++;
        if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b0) begin
            n_fail++; $display("FAIL reset_flags: in_ready=%b out_valid=%b required 0/0", bus.in_ready, bus.out_valid);
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        n_checks++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
            n_fail++; $display("FAIL reset_release: in_ready=%b out_valid=%b required 1/0", bus.in_ready, bus.out_valid);
        end
    endtask

    task automatic test_half_carry();
        bit ok; logic v1, v2; logic [34:1] got, exp;
        exp = ref_add(32'h0000FFFF, 32'h00000001, 1'b0);
        run_op(32'h0000FFFF, 32'h00000001, 1'b0, ok, v1, v2, got);
        n_checks++;
        if (!ok) begin n_fail++; $display("FAIL half_accept: in_ready never rose"); end
        n_checks++;
        if (v1 !== 1'b0 || v2 !== 1'b1) begin
            n_fail++; $display("FAIL half_latency: valid after edge1=%b edge2=%b required 0/1", v1, v2);
        end
        n_checks++;
        if (got !== exp || got[32:1] !== 32'h00010000) begin
            n_fail++; $display("FAIL half_result: got %h required %h", got, exp);
        end
        release_op();
        n_checks++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.sum !== 32'h00010000) begin
            n_fail++; $display("FAIL half_release: out_valid=%b in_ready=%b sum=%h required 0/1/00010000",
                               bus.out_valid, bus.in_ready, bus.sum);
        end
    endtask

    task automatic test_wrap_ovf();
        logic [32:1] ta [2] = '{32'hFFFFFFFF, 32'h7FFFFFFF};
        logic [32:1] tb [2] = '{32'h00000000, 32'h00000001};
        logic        tc [2] = '{1'b1, 1'b0};
        logic [34:1] want [2] = '{{1'b0, 1'b1, 32'h00000000}, {1'b1, 1'b0, 32'h80000000}};
        bit ok; logic v1, v2; logic [34:1] got;
        for (int i = 0; i < 2; i++) begin
            run_op(ta[i], tb[i], tc[i], ok, v1, v2, got);
            n_checks++;
            if (!ok || v2 !== 1'b1 || got !== want[i] || got !== ref_add(ta[i], tb[i], tc[i])) begin
                n_fail++; $display("FAIL wrap_ovf case %0d: got %h valid=%b required %h", i, got, v2, want[i]);
            end
            release_op();
        end
    endtask

    task automatic test_async_reset();
        #3;
        rst = 1'b1;
        #1;
        n_checks++;
        if (bus.sum !== 32'd0 || bus.ovf !== 1'b0 || bus.cout !== 1'b0 || bus.in_ready !== 1'b0) begin
            n_fail++; $display("FAIL async_reset: sum=%h ovf=%b cout=%b in_ready=%b required 0",
                               bus.sum, bus.ovf, bus.cout, bus.in_ready);
        end
        #1;
        rst = 1'b0;
        #1;
        n_checks++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
            n_fail++; $display("FAIL async_release: in_ready=%b out_valid=%b required 1/0", bus.in_ready, bus.out_valid);
        end
    endtask

    task automatic test_backpressure();
        bit ok; logic v1, v2; logic [34:1] got, exp;
        exp = ref_add(32'h01234567, 32'h89ABCDEF, 1'b1);
        run_op(32'h01234567, 32'h89ABCDEF, 1'b1, ok, v1, v2, got);
        n_checks++;
        if (!ok || v2 !== 1'b1 || got !== exp) begin
            n_fail++; $display("FAIL bp_result: got %h valid=%b required %h", got, v2, exp);
        end
        for (int i = 0; i < 5; i++) begin
            bus.a = $urandom; bus.b = $urandom; bus.in_valid = 1'(i & 1);
            step();
            n_checks++;
            if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0 || {bus.ovf, bus.cout, bus.sum} !== exp) begin
                n_fail++; $display("FAIL bp_hold cycle %0d: valid=%b in_ready=%b res=%h required 1/0/%h",
                                   i, bus.out_valid, bus.in_ready, {bus.ovf, bus.cout, bus.sum}, exp);
            end
        end
        bus.in_valid = 1'b0;
        release_op();
        n_checks++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.sum !== exp[32:1]) begin
            n_fail++; $display("FAIL bp_release: valid=%b in_ready=%b sum=%h required 0/1/%h",
                               bus.out_valid, bus.in_ready, bus.sum, exp[32:1]);
        end
    endtask

    task automatic test_abort();
        bit ok; logic v1, v2; logic [34:1] got;
        accept(32'h12345678, 32'h11111111, 1'b0, ok);
        step();
        #2;
        rst = 1'b1;
        #1;
        n_checks++;
        if (bus.out_valid !== 1'b0 || bus.sum !== 32'd0) begin
            n_fail++; $display("FAIL abort_reset: valid=%b sum=%h required 0/0", bus.out_valid, bus.sum);
        end
        repeat (2) step();
        #2;
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            n_checks++;
            if (bus.out_valid !== 1'b0) begin
                n_fail++; $display("FAIL abort_no_result cycle %0d: valid=%b required 0", i, bus.out_valid);
            end
        end
        run_op(32'h00000002, 32'h00000003, 1'b0, ok, v1, v2, got);
        n_checks++;
        if (!ok || v1 !== 1'b0 || v2 !== 1'b1 || got !== {2'b00, 32'h00000005}) begin
            n_fail++; $display("FAIL abort_recover: got %h valid=%b/%b required 000000005 valid 0/1", got, v1, v2);
        end
        release_op();
    endtask

    task automatic test_random();
        bit ok; bit done; logic r;
        logic [32:1] a, b; logic c; logic [34:1] exp;
        for (int n = 0; n < 1000; n++) begin
            repeat ($urandom_range(0, 2)) begin
                bus.out_ready = 1'($urandom_range(0, 1));
                step();
            end
            a = $urandom; b = $urandom; c = 1'($urandom_range(0, 1));
            if (n % 8 == 0) a = {1'b0, 31'h7FFFFFFF} ^ {32{n[4]}};
            exp = ref_add(a, b, c);
            accept(a, b, c, ok);
            n_checks++;
            if (!ok) begin n_fail++; $display("FAIL rand_accept op %0d: in_ready never rose", n); end
            for (int k = 0; k < 2; k++) begin
                n_checks++;
                if (bus.out_valid !== 1'b0) begin
                    n_fail++; $display("FAIL rand_early op %0d stage %0d: valid=%b required 0", n, k, bus.out_valid);
                end
                bus.a = $urandom; bus.b = $urandom; bus.cin = 1'($urandom_range(0, 1));
                bus.in_valid  = 1'($urandom_range(0, 1));
                bus.out_ready = 1'($urandom_range(0, 1));
                step();
            end
            bus.in_valid = 1'b0;
            n_checks++;
            if (bus.out_valid !== 1'b1 || {bus.ovf, bus.cout, bus.sum} !== exp) begin
                n_fail++; $display("FAIL rand_result op %0d: a=%h b=%h cin=%b got %h valid=%b required %h",
                                   n, a, b, c, {bus.ovf, bus.cout, bus.sum}, bus.out_valid, exp);
            end
            done = 1'b0;
            for (int w = 0; w < 64 && !done; w++) begin
                r = 1'($urandom_range(0, 1));
                bus.out_ready = r;
                bus.a = $urandom;
                step();
                if (r) begin
                    done = 1'b1;
                    n_checks++;
                    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
                        n_fail++; $display("FAIL rand_release op %0d: valid=%b in_ready=%b required 0/1",
                                           n, bus.out_valid, bus.in_ready);
                    end
                end else begin
                    n_checks++;
                    if (bus.out_valid !== 1'b1 || {bus.ovf, bus.cout, bus.sum} !== exp) begin
                        n_fail++; $display("FAIL rand_hold op %0d: got %h valid=%b required %h",
                                           n, {bus.ovf, bus.cout, bus.sum}, bus.out_valid, exp);
                    end
                end
            end
            if (!done) begin
                n_checks++; n_fail++;
                $display("FAIL rand_drain op %0d: out_ready never sampled high within bound", n);
                bus.out_ready = 1'b1;
                step();
            end
            bus.out_ready = 1'b0;
        end
    endtask

    initial begin
        test_reset();
        test_half_carry();
        test_wrap_ovf();
        test_async_reset();
        test_backpressure();
        test_abort();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/bka_seq_add32.md
BKA_SEQ_ADD32 -- requirements
Module: bka_seq_add32

Interface
REQ-001 The block SHALL have no parameters; datapath width is fixed at 32 bits, processed as two 16-bit halves.
REQ-002 clk  input  1  sole clock; all state changes on its rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 in_valid  input  1  operand set on a, b, cin is valid.
REQ-005 in_ready  output  1  block can accept an operand set this cycle.
REQ-006 a  input  [32:1]  operand A, bit 1 = LSB.
REQ-007 b  input  [32:1]  operand B, bit 1 = LSB.
REQ-008 cin  input  1  carry-in to bit 1.
REQ-009 out_valid  output  1  sum, cout and ovf hold a completed result.
REQ-010 out_ready  input  1  consumer takes the result this cycle.
REQ-011 sum  output  [32:1]  registered result (a + b + cin) mod 2^32.
REQ-012 cout  output  1  registered carry out of bit 32.
REQ-013 ovf  output  1  registered two's-complement overflow: a[32]==b[32] and sum[32]!=a[32].

Function
REQ-014 The block SHALL contain exactly one instance of the team's 16-bit Brent-Kung adder (port order S, Cout, A, B, Cin) and SHALL perform all addition through it, one half per cycle.
REQ-015 The state machine SHALL have four states: IDLE, LO, HI, HOLD.
REQ-016 in_ready SHALL be 1 only in IDLE with rst low; it is 0 in every other state.
REQ-017 Accept: at a rising edge with in_valid=1 and in_ready=1, the block SHALL register a, b and cin and move IDLE->LO; with in_valid=0 it remains in IDLE.
REQ-018 LO: adder inputs are a_reg[16:1], b_reg[16:1], cin_reg; at the next edge the block SHALL register sum_lo and carry_lo, then move to HI.
REQ-019 HI: adder inputs are a_reg[32:17], b_reg[32:17], carry_lo; at the next edge the block SHALL load sum = {adder S, sum_lo}, cout = adder Cout and ovf per REQ-013, set out_valid=1, and move to HOLD.
REQ-020 Latency: out_valid SHALL first be observed high after the second rising edge following the accept edge.
REQ-021 HOLD: sum, cout, ovf and out_valid SHALL stay stable while out_ready=0; at an edge with out_ready=1 the block SHALL clear out_valid and move to IDLE. sum, cout and ovf then keep their last values.
REQ-022 Peak throughput SHALL be one operation per 4 cycles (accept, LO, HI, HOLD with out_ready=1).
REQ-023 Changes on a, b, cin or in_valid outside the accept edge SHALL NOT affect an operation in progress.
REQ-024 out_ready SHALL be ignored outside HOLD.
REQ-025 Carry SHALL propagate from bit 16 to bit 17 only through carry_lo; no other path between the two halves is allowed.

Reset
REQ-026 While rst=1, the block SHALL force state=IDLE, out_valid=0, sum=0, cout=0, ovf=0, in_ready=0, and clear all operand and carry registers, independent of clk.
REQ-027 Reset asserted in LO, HI or HOLD SHALL abort the operation with no result emitted. After release, the first accept SHALL complete normally.

Verification
REQ-028 Reset: pulse rst asynchronously between edges -> outputs 0 immediately; after release, in_ready=1, out_valid=0.
REQ-029 Half-boundary carry: a=0x0000FFFF, b=0x00000001, cin=0 -> sum=0x00010000, cout=0, ovf=0, out_valid after 2nd edge post-accept.
REQ-030 Full wrap: a=0xFFFFFFFF, b=0x00000000, cin=1 -> sum=0x00000000, cout=1, ovf=0. Signed overflow: a=0x7FFFFFFF, b=0x00000001, cin=0 -> sum=0x80000000, cout=0, ovf=1.
REQ-031 Backpressure: hold out_ready=0 for 5 cycles while toggling a/b/in_valid -> out_valid=1 and sum unchanged, in_ready=0; out_ready=1 for one edge -> out_valid=0, in_ready=1.
REQ-032 Abort: assert rst while in HI for a=0x12345678, b=0x11111111 -> out_valid never rises. After release, a=0x00000002, b=0x00000003 -> sum=0x00000005.
REQ-033 Random: run at least 1000 accepted operations with random out_ready; every result SHALL equal the 33-bit reference a+b+cin, and ovf SHALL match REQ-013.
